mem_bus_arbiter: RTL and testbench

//  Shares one SRAM-like memory bus between instruction fetch (IF) and the data

---
 rtl/mem_bus_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one SRAM-like bus between instruction fetch and the data port.
// Data wins by default; a starvation counter forces an IF grant after STARVE_LIMIT data grants.
module mem_bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    state_t        state_r;
    state_t        state_s;
    logic          owner_r;
    logic          owner_s;
    logic [CW-1:0] starve_cnt_r;
    logic [CW-1:0] starve_cnt_s;
    cmd_t          cmd_r;
    cmd_t          cmd_s;
    logic          grant_data_s;
    logic          in_addr_s;
    logic          in_wait_s;

    // State, owner, starvation counter and latched command registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r      <= ST_IDLE;
            owner_r      <= 1'b0;
            starve_cnt_r <= '0;
            cmd_r        <= '0;
        end else begin
            state_r      <= state_s;
            owner_r      <= owner_s;
            starve_cnt_r <= starve_cnt_s;
            cmd_r        <= cmd_s;
        end
    end

    // Arbitration, command capture and transaction sequencing.
    always_comb begin
        state_s      = state_r;
        owner_s      = owner_r;
        starve_cnt_s = starve_cnt_r;
        cmd_s        = cmd_r;
        grant_data_s = data_req && !(inst_req && (starve_cnt_r == LIMIT_C));
        case (state_r)
            ST_IDLE: begin
                if (grant_data_s) begin
                    owner_s     = 1'b1;
                    state_s     = ST_ADDR;
                    cmd_s.wr    = data_wr;
                    cmd_s.size  = data_size;
                    cmd_s.wstrb = data_wr ? data_wstrb : 4'b0000;
                    cmd_s.addr  = data_addr;
                    cmd_s.wdata = data_wdata;
                    if (inst_req) begin
                        starve_cnt_s = (starve_cnt_r == LIMIT_C) ? starve_cnt_r
                                                                 : starve_cnt_r + ONE_C;
                    end else begin
                        starve_cnt_s = '0;
                    end
                end else if (inst_req) begin
                    owner_s      = 1'b0;
                    state_s      = ST_ADDR;
                    starve_cnt_s = '0;
                    cmd_s.wr     = 1'b0;
                    cmd_s.size   = 2'b10;
                    cmd_s.wstrb  = 4'b0000;
                    cmd_s.addr   = inst_addr;
                    cmd_s.wdata  = 32'h0000_0000;
                end else begin
                    starve_cnt_s = '0;
                end
            end
            ST_ADDR: begin
                if (bus_addr_ok) begin
                    state_s = bus_data_ok ? ST_IDLE : ST_WAIT;
                end else begin
                    state_s = ST_ADDR;
                end
            end
            ST_WAIT: begin
                if (bus_data_ok) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    assign in_addr_s = (state_r == ST_ADDR);
    assign in_wait_s = (state_r == ST_WAIT);

    // Bus command is only presented while the address phase is open.
    assign bus_req   = in_addr_s;
    assign bus_wr    = in_addr_s & cmd_r.wr;
    assign bus_size  = in_addr_s ? cmd_r.size  : 2'b00;
    assign bus_wstrb = in_addr_s ? cmd_r.wstrb : 4'b0000;
    assign bus_addr  = in_addr_s ? cmd_r.addr  : 32'h0000_0000;
    assign bus_wdata = in_addr_s ? cmd_r.wdata : 32'h0000_0000;

    assign inst_addr_ok = in_addr_s & bus_addr_ok & ~owner_r;
    assign data_addr_ok = in_addr_s & bus_addr_ok &  owner_r;
    assign inst_data_ok = ((in_addr_s & bus_addr_ok) | in_wait_s) & bus_data_ok & ~owner_r;
    assign data_data_ok = ((in_addr_s & bus_addr_ok) | in_wait_s) & bus_data_ok &  owner_r;

    assign inst_rdata = bus_rdata;
    assign data_rdata = bus_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: expected bus commands are queued when
// requests are raised and checked as each transaction appears on the bus.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = 32'h0;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req = 1'b0;
    logic        data_wr = 1'b0;
    logic [1:0]  data_size = 2'b00;
    logic [3:0]  data_wstrb = 4'b0000;
    logic [31:0] data_addr = 32'h0;
    logic [31:0] data_wdata = 32'h0;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_addr_ok = 1'b0;
    logic        bus_data_ok = 1'b0;
    logic [31:0] bus_rdata = 32'h0;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        own;
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        drop;
    } exp_t;

    exp_t sb[$];

    mem_bus_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic push(input logic own, input logic wr, input logic [1:0] size,
                        input logic [3:0] wstrb, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata, input logic drop);
        exp_t e;
        e.own = own; e.wr = wr; e.size = size; e.wstrb = wstrb;
        e.addr = addr; e.wdata = wdata; e.rdata = rdata; e.drop = drop;
        sb.push_back(e);
    endtask

    // Bus responder: pops the next expected command and plays the bus side.
    task automatic serve_txn(input string tag, input int addr_lat, input logic same, output int lat);
        exp_t e;
        logic [1:0] want_ok;
        lat = 0;
        while (bus_req !== 1'b1 && lat < 20) begin
            @(negedge clk); #1; lat++;
        end
        n_cmp++;
        if (bus_req !== 1'b1 || sb.size() == 0) begin
            n_bad++;
            $display("FAIL %s grant: bus_req=%b queued=%0d, required bus_req=1 with a queued entry",
                     tag, bus_req, sb.size());
            return;
        end
        e = sb.pop_front();
        n_cmp++;
        if ({bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata} !== {e.wr, e.size, e.wstrb, e.addr, e.wdata}) begin
            n_bad++;
            $display("FAIL %s cmd: got wr=%b size=%0d strb=%b addr=%h wdata=%h, required wr=%b size=%0d strb=%b addr=%h wdata=%h",
                     tag, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata, e.wr, e.size, e.wstrb, e.addr, e.wdata);
        end
        repeat (addr_lat) begin @(negedge clk); #1; end
        bus_addr_ok = 1'b1;
        if (same) begin bus_data_ok = 1'b1; bus_rdata = e.rdata; end
        #1;
        want_ok = e.own ? 2'b01 : 2'b10;
        n_cmp++;
        if ({inst_addr_ok, data_addr_ok} !== want_ok) begin
            n_bad++;
            $display("FAIL %s addr_ok: got inst/data=%b, required %b", tag, {inst_addr_ok, data_addr_ok}, want_ok);
        end
        if (same) begin
            n_cmp++;
            if ({inst_data_ok, data_data_ok} !== want_ok || inst_rdata !== e.rdata || data_rdata !== e.rdata) begin
                n_bad++;
                $display("FAIL %s same-cycle data_ok: got inst/data=%b rdata=%h, required %b rdata=%h",
                         tag, {inst_data_ok, data_data_ok}, data_rdata, want_ok, e.rdata);
            end
        end
        @(negedge clk);
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        if (e.drop) begin
            if (e.own) data_req = 1'b0;
            else inst_req = 1'b0;
        end
        #1;
        if (!same) begin
            n_cmp++;
            if ({bus_req, inst_data_ok, data_data_ok} !== 3'b000) begin
                n_bad++;
                $display("FAIL %s wait phase: got bus_req/inst_dok/data_dok=%b, required 000",
                         tag, {bus_req, inst_data_ok, data_data_ok});
            end
            @(negedge clk);
            bus_data_ok = 1'b1;
            bus_rdata = e.rdata;
            #1;
            n_cmp++;
            if ({inst_data_ok, data_data_ok} !== want_ok || inst_rdata !== e.rdata || data_rdata !== e.rdata) begin
                n_bad++;
                $display("FAIL %s data_ok: got inst/data=%b rdata=%h, required %b rdata=%h",
                         tag, {inst_data_ok, data_data_ok}, data_rdata, want_ok, e.rdata);
            end
            @(negedge clk);
            bus_data_ok = 1'b0;
            #1;
        end
    endtask

    task automatic check_quiet(input string tag);
        n_cmp++;
        if ({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, bus_req, bus_wr,
             bus_size, bus_wstrb, bus_addr, bus_wdata} !== 76'h0 ||
            inst_rdata !== bus_rdata || data_rdata !== bus_rdata) begin
            n_bad++;
            $display("FAIL %s quiet: got oks=%b bus_req=%b addr=%h rdata=%h, required all 0 and rdata=%h",
                     tag, {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, bus_req, bus_addr,
                     data_rdata, bus_rdata);
        end
    endtask

    task automatic test_reset();
        bus_rdata = 32'h55AA_55AA;
        data_req = 1'b1;
        #1;
        check_quiet("reset_held");
        @(negedge clk); data_req = 1'b0;
        @(negedge clk); resetn = 1'b1; #1;
        check_quiet("after_release");
        @(negedge clk); bus_addr_ok = 1'b1; bus_data_ok = 1'b1; #1;
        n_cmp++;
        if ({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, bus_req} !== 5'b00000) begin
            n_bad++;
            $display("FAIL idle_spurious_ok: got oks/bus_req=%b, required 00000",
                     {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, bus_req});
        end
        @(negedge clk); bus_addr_ok = 1'b0; bus_data_ok = 1'b0; #1;
        check_quiet("idle_after_spurious");
    endtask

    task automatic test_load();
        int lat;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_wstrb = 4'hF;
        data_addr = 32'h8000_0010; data_wdata = 32'h0;
        push(1'b1, 1'b0, 2'd2, 4'b0000, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 1'b1);
        serve_txn("load", 1, 1'b0, lat);
        n_cmp++;
        if (lat !== 1) begin
            n_bad++;
            $display("FAIL load grant latency: got %0d cycles, required 1", lat);
        end
    endtask

    task automatic test_priority();
        int lat;
        inst_req = 1'b1; inst_addr = 32'h1000_0000;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_wstrb = 4'b0000;
        data_addr = 32'h2000_0004;
        push(1'b1, 1'b0, 2'd2, 4'b0000, 32'h2000_0004, 32'h0, 32'h1111_2222, 1'b1);
        push(1'b0, 1'b0, 2'd2, 4'b0000, 32'h1000_0000, 32'h0, 32'h3333_4444, 1'b1);
        serve_txn("prio_data", 1, 1'b0, lat);
        serve_txn("prio_inst", 1, 1'b0, lat);
        n_cmp++;
        if (lat !== 1) begin
            n_bad++;
            $display("FAIL prio IF re-arbitration gap: got %0d cycles, required 1", lat);
        end
    endtask

    task automatic test_starvation();
        int lat;
        inst_req = 1'b1; inst_addr = 32'h1000_0040;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd1; data_addr = 32'h2000_0100;
        for (int i = 0; i < 4; i++)
            push(1'b1, 1'b0, 2'd1, 4'b0000, 32'h2000_0100, 32'h0, 32'hA000_0000 + i, 1'b0);
        push(1'b0, 1'b0, 2'd2, 4'b0000, 32'h1000_0040, 32'h0, 32'hB000_0000, 1'b1);
        push(1'b1, 1'b0, 2'd1, 4'b0000, 32'h2000_0100, 32'h0, 32'hC000_0000, 1'b1);
        for (int i = 0; i < 6; i++)
            serve_txn($sformatf("starve%0d", i), 0, 1'b0, lat);
    endtask

    task automatic test_store();
        int lat;
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0; data_wstrb = 4'b1000;
        data_addr = 32'h0000_0003; data_wdata = 32'hAB00_0000;
        push(1'b1, 1'b1, 2'd0, 4'b1000, 32'h0000_0003, 32'hAB00_0000, 32'h0000_0000, 1'b1);
        serve_txn("store", 2, 1'b0, lat);
        data_wr = 1'b0; data_wstrb = 4'b0000; data_wdata = 32'h0;
    endtask

    task automatic test_same_cycle();
        int lat;
        data_req = 1'b1; data_size = 2'd2; data_addr = 32'h3000_0008;
        push(1'b1, 1'b0, 2'd2, 4'b0000, 32'h3000_0008, 32'h0, 32'h0F0F_0F0F, 1'b1);
        serve_txn("same_data", 0, 1'b1, lat);
        inst_req = 1'b1; inst_addr = 32'h1000_0080;
        push(1'b0, 1'b0, 2'd2, 4'b0000, 32'h1000_0080, 32'h0, 32'h7777_8888, 1'b1);
        serve_txn("same_inst", 1, 1'b1, lat);
        n_cmp++;
        if (lat !== 1) begin
            n_bad++;
            $display("FAIL same-cycle return to IDLE: got %0d cycles to next grant, required 1", lat);
        end
    endtask

    task automatic test_reset_in_wait();
        int lat;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h4000_0000;
        @(negedge clk); bus_addr_ok = 1'b1; #1;
        @(negedge clk); bus_addr_ok = 1'b0; data_req = 1'b0; #1;
        n_cmp++;
        if (bus_req !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_wait entry: got bus_req=%b, required 0", bus_req);
        end
        #2; resetn = 1'b0; bus_rdata = 32'h0BAD_F00D; #1;
        check_quiet("rst_in_wait");
        @(negedge clk); bus_data_ok = 1'b1; #1;
        check_quiet("rst_data_ok_held");
        @(negedge clk); resetn = 1'b1; #1;
        check_quiet("rst_released_late_data_ok");
        @(negedge clk); bus_data_ok = 1'b0; #1;
        check_quiet("rst_idle");
        data_req = 1'b1; data_addr = 32'h4000_0020;
        push(1'b1, 1'b0, 2'd2, 4'b0000, 32'h4000_0020, 32'h0, 32'h9999_AAAA, 1'b1);
        serve_txn("after_reset", 1, 1'b0, lat);
    endtask

    initial begin
        test_reset();
        test_load();
        test_priority();
        test_starvation();
        test_store();
        test_same_cycle();
        test_reset_in_wait();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard drain: got %0d entries left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
